// File: rtl/key_search_scheduler.sv
// Brute-force RC4 key-search scheduler: hands consecutive keys to NUM_ENGINES decrypt engines
// and keeps the smallest key whose plaintext is all upper-case letters, digits and spaces.
module key_search_scheduler #(
    parameter int NUM_ENGINES = 4,
    parameter int KEY_WIDTH   = 24
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    output logic [NUM_ENGINES-1:0]           eng_enable,
    output logic [NUM_ENGINES*KEY_WIDTH-1:0] eng_key,
    input  logic [NUM_ENGINES-1:0]           eng_done,
    input  logic [NUM_ENGINES*128-1:0]       eng_plaintext,
    output logic                             busy,
    output logic                             found,
    output logic                             exhausted,
    output logic [KEY_WIDTH-1:0]             found_key,
    output logic [127:0]                     found_plaintext
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_DRAIN     = 3'd2,
        S_FOUND     = 3'd3,
        S_EXHAUSTED = 3'd4
    } state_t;

    state_t                           state_r, state_nxt_s;
    logic [KEY_WIDTH:0]               next_key_r, next_key_nxt_s;
    logic [NUM_ENGINES-1:0]           eng_enable_r, enable_nxt_s;
    logic [NUM_ENGINES*KEY_WIDTH-1:0] eng_key_r;
    logic                             match_valid_r;
    logic [KEY_WIDTH-1:0]             match_key_r;
    logic [127:0]                     match_pt_r;
    logic                             busy_r, found_r, exhausted_r;

    logic [NUM_ENGINES-1:0] completing_s, disp_onehot_s;
    logic                   hit_s, idle_found_s, disp_s, clear_match_s, update_match_s;
    logic [KEY_WIDTH-1:0]   hit_key_s;
    logic [127:0]           hit_pt_s;

    function automatic logic is_printable(input logic [127:0] text);
        logic       ok;
        logic [7:0] c;
        ok = 1'b1;
        for (int b = 0; b < 16; b++) begin
            c = text[b*8 +: 8];
            if (!(((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h30) && (c <= 8'h39)) || (c == 8'h20)))
                ok = 1'b0;
            else
                ok = ok;
        end
        return ok;
    endfunction

    // Completion detection and smallest-key selection among this cycle's matches
    always_comb begin
        completing_s = ((state_r == S_RUN) || (state_r == S_DRAIN)) ? (eng_enable_r & eng_done)
                                                                    : {NUM_ENGINES{1'b0}};
        hit_s     = 1'b0;
        hit_key_s = {KEY_WIDTH{1'b0}};
        hit_pt_s  = 128'd0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (completing_s[i] && is_printable(eng_plaintext[i*128 +: 128]) &&
                (!hit_s || (eng_key_r[i*KEY_WIDTH +: KEY_WIDTH] < hit_key_s))) begin
                hit_s     = 1'b1;
                hit_key_s = eng_key_r[i*KEY_WIDTH +: KEY_WIDTH];
                hit_pt_s  = eng_plaintext[i*128 +: 128];
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Dispatch to the lowest-index engine whose enable was low before this edge
    always_comb begin
        idle_found_s  = 1'b0;
        disp_onehot_s = {NUM_ENGINES{1'b0}};
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (!eng_enable_r[i] && !idle_found_s) begin
                idle_found_s     = 1'b1;
                disp_onehot_s[i] = 1'b1;
            end else begin
                idle_found_s = idle_found_s;
            end
        end
        disp_s         = (state_r == S_RUN) && !abort && !hit_s && !next_key_r[KEY_WIDTH] && idle_found_s;
        clear_match_s  = (state_r == S_IDLE) && start && !abort;
        update_match_s = !abort && hit_s && (!match_valid_r || (hit_key_s < match_key_r));
        if (abort)
            enable_nxt_s = {NUM_ENGINES{1'b0}};
        else if (disp_s)
            enable_nxt_s = (eng_enable_r & ~completing_s) | disp_onehot_s;
        else
            enable_nxt_s = eng_enable_r & ~completing_s;
        if (clear_match_s)
            next_key_nxt_s = {(KEY_WIDTH+1){1'b0}};
        else if (disp_s)
            next_key_nxt_s = next_key_r + {{KEY_WIDTH{1'b0}}, 1'b1};
        else
            next_key_nxt_s = next_key_r;
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_nxt_s = S_RUN;
                else       state_nxt_s = S_IDLE;
            end
            S_RUN: begin
                if (hit_s)
                    state_nxt_s = (enable_nxt_s == {NUM_ENGINES{1'b0}}) ? S_FOUND : S_DRAIN;
                else if (next_key_nxt_s[KEY_WIDTH] && (enable_nxt_s == {NUM_ENGINES{1'b0}}))
                    state_nxt_s = S_EXHAUSTED;
                else
                    state_nxt_s = S_RUN;
            end
            S_DRAIN: begin
                if (enable_nxt_s == {NUM_ENGINES{1'b0}}) state_nxt_s = S_FOUND;
                else                                     state_nxt_s = S_DRAIN;
            end
            S_FOUND:     state_nxt_s = S_FOUND;
            S_EXHAUSTED: state_nxt_s = S_EXHAUSTED;
            default:     state_nxt_s = S_IDLE;
        endcase
        if (abort) state_nxt_s = S_IDLE;
        else       state_nxt_s = state_nxt_s;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_r <= S_IDLE;
        else       state_r <= state_nxt_s;
    end

    // Engine control, key counter, match register and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            next_key_r    <= {(KEY_WIDTH+1){1'b0}};
            eng_enable_r  <= {NUM_ENGINES{1'b0}};
            eng_key_r     <= {(NUM_ENGINES*KEY_WIDTH){1'b0}};
            match_valid_r <= 1'b0;
            match_key_r   <= {KEY_WIDTH{1'b0}};
            match_pt_r    <= 128'd0;
            busy_r        <= 1'b0;
            found_r       <= 1'b0;
            exhausted_r   <= 1'b0;
        end else begin
            next_key_r   <= next_key_nxt_s;
            eng_enable_r <= enable_nxt_s;
            for (int i = 0; i < NUM_ENGINES; i++) begin
                if (disp_s && disp_onehot_s[i])
                    eng_key_r[i*KEY_WIDTH +: KEY_WIDTH] <= next_key_r[KEY_WIDTH-1:0];
            end
            if (clear_match_s) begin
                match_valid_r <= 1'b0;
                match_key_r   <= {KEY_WIDTH{1'b0}};
                match_pt_r    <= 128'd0;
            end else if (update_match_s) begin
                match_valid_r <= 1'b1;
                match_key_r   <= hit_key_s;
                match_pt_r    <= hit_pt_s;
            end
            busy_r      <= (state_nxt_s == S_RUN) || (state_nxt_s == S_DRAIN);
            found_r     <= (state_nxt_s == S_FOUND);
            exhausted_r <= (state_nxt_s == S_EXHAUSTED);
        end
    end

    assign eng_enable      = eng_enable_r;
    assign eng_key         = eng_key_r;
    assign busy            = busy_r;
    assign found           = found_r;
    assign exhausted       = exhausted_r;
    assign found_key       = match_key_r;
    assign found_plaintext = match_pt_r;

endmodule

// File: tb/tb_key_search_scheduler.sv
// Bench for key_search_scheduler: behavioural RC4 engine models with per-key latency and
// chosen printable keys; expected results follow from the search rules (smallest matching key).
module tb_key_search_scheduler;
    localparam int NE = 4;
    localparam int KW = 4;
    localparam int NK = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [NE-1:0]        eng_enable;
    logic [NE*KW-1:0]     eng_key;
    logic [NE-1:0]        eng_done;
    logic [NE*128-1:0]    eng_plaintext;
    logic                 busy, found, exhausted;
    logic [KW-1:0]        found_key;
    logic [127:0]         found_plaintext;

    key_search_scheduler #(.NUM_ENGINES(NE), .KEY_WIDTH(KW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .eng_enable(eng_enable), .eng_key(eng_key), .eng_done(eng_done),
        .eng_plaintext(eng_plaintext), .busy(busy), .found(found), .exhausted(exhausted),
        .found_key(found_key), .found_plaintext(found_plaintext)
    );

    int            lat [NK];
    bit            is_match [NK];
    logic [NE-1:0] force_done = '0;
    logic [NE-1:0] done_m = '0;
    int            cnt [NE];
    assign eng_done = done_m | force_done;

    int checks = 0;
    int passes = 0;
    int search_id = 0;

    // Printable text for matching keys; otherwise one out-of-set byte at a key-dependent position
    function automatic logic [127:0] text_for(int k, bit m);
        logic [127:0] t;
        logic [7:0]   bad;
        if (m) begin
            t = {"FOUND KEY NUM 0", (k < 10) ? 8'(8'h30 + k) : 8'(8'h37 + k)};
        end else begin
            t = "ALMOST VALID TXT";
            case (k % 8)
                0: bad = 8'h40;
                1: bad = 8'h5B;
                2: bad = 8'h2F;
                3: bad = 8'h3A;
                4: bad = 8'h1F;
                5: bad = 8'h61;
                6: bad = 8'h7E;
                default: bad = 8'h00;
            endcase
            t[(k % 16)*8 +: 8] = bad;
        end
        return t;
    endfunction

    // Engine model: done after lat[key] enabled cycles, cleared whenever enable is low
    always @(negedge clk) begin
        for (int i = 0; i < NE; i++) begin
            int k;
            k = int'(eng_key[i*KW +: KW]);
            if (!eng_enable[i]) begin
                cnt[i] = 0;
                done_m[i] = 1'b0;
            end else begin
                cnt[i] = cnt[i] + 1;
                done_m[i] = (cnt[i] >= lat[k]);
            end
            eng_plaintext[i*128 +: 128] = text_for(k, is_match[k]);
        end
    end

    // Dispatch monitor: per-search key counts, ordering and completion record
    int            seen_id = -1;
    int            disp_cnt [NK];
    bit            fell [NK];
    int            order_err = 0;
    int            last_key = -1;
    logic [NE-1:0] prev_en = '0;
    always @(negedge clk) begin
        int rises;
        if (seen_id != search_id) begin
            seen_id = search_id;
            for (int k = 0; k < NK; k++) begin
                disp_cnt[k] = 0;
                fell[k] = 1'b0;
            end
            order_err = 0;
            last_key = -1;
        end
        rises = 0;
        for (int i = 0; i < NE; i++) begin
            int k;
            k = int'(eng_key[i*KW +: KW]);
            if (eng_enable[i] && !prev_en[i]) begin
                rises++;
                if (k <= last_key) order_err++;
                last_key = k;
                disp_cnt[k]++;
            end
            if (!eng_enable[i] && prev_en[i]) fell[k] = 1'b1;
        end
        if (rises > 1) order_err++;
        prev_en = eng_enable;
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic begin_search();
        search_id++;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic go_idle();
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
    endtask

    task automatic wait_end(string tag, int budget);
        for (int n = 0; n < budget && !(found || exhausted); n++) cyc(1);
        check({tag, "_terminated"}, found | exhausted, 1'b1);
    endtask

    task automatic check_idle_outputs(string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_found"}, found, 1'b0);
        check({tag, "_exhausted"}, exhausted, 1'b0);
        check({tag, "_enable"}, eng_enable, 4'h0);
        check({tag, "_keys"}, eng_key, 16'h0);
        check({tag, "_found_key"}, found_key, 4'h0);
        check({tag, "_found_pt"}, found_plaintext, 128'd0);
    endtask

    task automatic set_keys(int latency, int m0, int m1);
        for (int k = 0; k < NK; k++) begin
            lat[k] = latency;
            is_match[k] = (k == m0) || (k == m1);
        end
    endtask

    // Expected outcome: the smallest matching key in the whole space, or exhaustion
    task automatic check_result(string tag);
        int m, dup, once;
        m = -1;
        for (int k = NK - 1; k >= 0; k--) if (is_match[k]) m = k;
        dup = 0;
        once = 0;
        for (int k = 0; k < NK; k++) begin
            if (disp_cnt[k] > 1) dup++;
            if (disp_cnt[k] == 1) once++;
        end
        check({tag, "_found"}, found, m >= 0);
        check({tag, "_exhausted"}, exhausted, m < 0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_found_key"}, found_key, (m >= 0) ? 128'(m) : 128'd0);
        check({tag, "_found_pt"}, found_plaintext, (m >= 0) ? text_for(m, 1'b1) : 128'd0);
        check({tag, "_order"}, order_err, 0);
        check({tag, "_dup_dispatch"}, dup, 0);
        if (m < 0) check({tag, "_all_dispatched"}, once, NK);
    endtask

    initial begin
        int sum;
        set_keys(5, 9, -1);

        // Reset held two cycles
        cyc(2);
        reset = 1'b0;
        check_idle_outputs("reset");

        // Start timing: busy after edge k, engine i enabled after edge k+1+i with key i
        begin_search();
        check("start_busy", busy, 1'b1);
        check("start_no_enable_yet", eng_enable, 4'h0);
        for (int i = 0; i < NE; i++) begin
            cyc(1);
            check($sformatf("start_enable_%0d", i), eng_enable, 128'((1 << (i + 1)) - 1));
            check($sformatf("start_key_%0d", i), eng_key[i*KW +: KW], 128'(i));
        end

        // Single match at key 9
        wait_end("single", 300);
        check_result("single");
        sum = 0;
        for (int k = 13; k < NK; k++) sum += disp_cnt[k];
        check("single_late_keys", sum, 0);

        // Out-of-order matches: key 7 completes first, key 5 must win
        go_idle();
        set_keys(2, 5, 7);
        lat[5] = 20;
        lat[7] = 3;
        begin_search();
        wait_end("ooo", 300);
        check_result("ooo");
        check("ooo_key15_unused", disp_cnt[15], 0);

        // No match: full key space dispatched once, then exhausted
        go_idle();
        set_keys(1, -1, -1);
        for (int k = 0; k < NK; k++) lat[k] = $urandom_range(1, 6);
        begin_search();
        wait_end("nomatch", 400);
        check_result("nomatch");

        // Abort while all engines busy; later done pulses are ignored
        go_idle();
        set_keys(30, -1, -1);
        begin_search();
        cyc(4);
        check("abort_all_busy", eng_enable, 4'hF);
        go_idle();
        check("abort_enable", eng_enable, 4'h0);
        check("abort_busy", busy, 1'b0);
        force_done = 4'hF;
        cyc(3);
        check("abort_done_ignored_en", eng_enable, 4'h0);
        check("abort_done_ignored_busy", busy, 1'b0);
        force_done = 4'h0;
        begin_search();
        cyc(1);
        check("restart_enable", eng_enable, 4'h1);
        check("restart_key0", eng_key[KW-1:0], 4'h0);

        // Reset while draining
        go_idle();
        set_keys(2, 5, 7);
        lat[5] = 20;
        lat[7] = 3;
        begin_search();
        for (int n = 0; n < 60 && !fell[7]; n++) cyc(1);
        check("drain_key7_done", fell[7], 1'b1);
        check("drain_key5_pending", fell[5], 1'b0);
        check("drain_busy", busy, 1'b1);
        check("drain_not_found", found, 1'b0);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check_idle_outputs("reset_drain");

        // Fresh search after reset, then reset in FOUND
        set_keys(3, 12, -1);
        begin_search();
        wait_end("fresh", 300);
        check_result("fresh");
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check_idle_outputs("reset_found");

        // Randomized latencies and match sets
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < NK; k++) begin
                lat[k] = $urandom_range(1, 8);
                is_match[k] = ($urandom_range(0, 5) == 0);
            end
            begin_search();
            wait_end($sformatf("rand%0d", it), 400);
            check_result($sformatf("rand%0d", it));
            go_idle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
